loba_mult_pipe: RTL and testbench

- Pipelined, parametrised LOBA (leading-one-based approximate) multiplier.
- Generalises the fixed-configuration LOBA0..3 combinational multipliers into one block:
  - number of partial products selected at run time per transaction;
  - signed/unsigned selected at run time per transaction;
  - 3-stage pipeline with valid/ready backpressure.
- Sits in MAxPy accelerator datapaths as a drop-in approximate multiply unit.

---
 rtl/loba_mult_pipe.sv | 140 ++++++++++++++
 tb/tb_loba_mult_pipe.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loba_mult_pipe.sv
// Pipelined leading-one-based approximate multiplier with per-beat selection of
// partial-product count and signedness; three stages with valid/ready flow control.
module loba_mult_pipe #(
  parameter int unsigned N = 16,
  parameter int unsigned K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic [1:0]     mode,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] r
);

  localparam int unsigned KW = $clog2(N);
  localparam int unsigned SW = $clog2(2 * N);
  localparam int unsigned PW = 2 * N;
  localparam int unsigned MW = 2 * K;
  localparam int unsigned XW = 2 * K + 2 * KW;

  // Index of the highest set bit; zero input reports 0.
  function automatic logic [KW-1:0] msb_of(input logic [N-1:0] x);
    msb_of = '0;
    for (int i = 0; i < int'(N); i++)
      if (x[i]) msb_of = KW'(i);
  endfunction

  // Returns {high window, low window, high position, low position}.
  function automatic logic [XW-1:0] split(input logic [N-1:0] x);
    logic [KW-1:0] kh;
    logic [KW-1:0] kl;
    logic [N-1:0]  low;
    logic [K-1:0]  xh;
    logic [K-1:0]  xl;
    kh = msb_of(x);
    if (kh < KW'(K - 1)) kh = KW'(K - 1);
    xh  = x[kh -: K];
    low = x & ((N'(1) << (kh - KW'(K - 1))) - N'(1));
    kl  = msb_of(low);
    if (kl < KW'(K - 1)) kl = KW'(K - 1);
    xl  = low[kl -: K];
    split = {xh, xl, kh, kl};
  endfunction

  // Window product placed back at the weight of both leading windows.
  function automatic logic [PW-1:0] pp(input logic [K-1:0] x, input logic [K-1:0] y,
                                       input logic [KW-1:0] p, input logic [KW-1:0] q);
    logic [SW-1:0] s;
    logic [MW-1:0] prod;
    s    = SW'(p) + SW'(q) - SW'(2 * (K - 1));
    prod = {{K{1'b0}}, x} * {{K{1'b0}}, y};
    pp   = {{(PW - MW){1'b0}}, prod} << s;
  endfunction

  logic rdy2, rdy3;

  logic          s1_v, s1_neg;
  logic [1:0]    s1_mode;
  logic [K-1:0]  s1_ah, s1_al, s1_bh, s1_bl;
  logic [KW-1:0] s1_kha, s1_kla, s1_khb, s1_klb;

  logic               s2_v, s2_neg;
  logic [3:0][PW-1:0] s2_t;

  logic [N-1:0]       mag_a, mag_b;
  logic [XW-1:0]      sp_a, sp_b;
  logic [3:0][PW-1:0] terms;
  logic [PW-1:0]      sum;

  assign rdy3     = !out_valid || out_ready;
  assign rdy2     = !s2_v || rdy3;
  assign in_ready = !s1_v || rdy2;

  // S1: magnitude and window split
  always_comb begin
    mag_a = (sgn && a[N-1]) ? -a : a;
    mag_b = (sgn && b[N-1]) ? -b : b;
    sp_a  = split(mag_a);
    sp_b  = split(mag_b);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_neg  <= 1'b0;
      s1_mode <= '0;
      {s1_ah, s1_al, s1_kha, s1_kla} <= '0;
      {s1_bh, s1_bl, s1_khb, s1_klb} <= '0;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_neg  <= sgn && (a[N-1] ^ b[N-1]);
        s1_mode <= mode;
        {s1_ah, s1_al, s1_kha, s1_kla} <= sp_a;
        {s1_bh, s1_bl, s1_khb, s1_klb} <= sp_b;
      end
    end
  end

  // S2: partial products, terms beyond the selected count forced to zero
  always_comb begin
    terms[0] = pp(s1_ah, s1_bh, s1_kha, s1_khb);
    terms[1] = (s1_mode >= 2'd1) ? pp(s1_ah, s1_bl, s1_kha, s1_klb) : '0;
    terms[2] = (s1_mode >= 2'd2) ? pp(s1_al, s1_bh, s1_kla, s1_khb) : '0;
    terms[3] = (s1_mode == 2'd3) ? pp(s1_al, s1_bl, s1_kla, s1_klb) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      s2_neg <= 1'b0;
      s2_t   <= '0;
    end else if (rdy2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_neg <= s1_neg;
        s2_t   <= terms;
      end
    end
  end

  // S3: accumulate and restore sign
  assign sum = s2_t[0] + s2_t[1] + s2_t[2] + s2_t[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
    end else if (rdy3) begin
      out_valid <= s2_v;
      if (s2_v) r <= s2_neg ? -sum : sum;
    end
  end

endmodule

// File: tb/tb_loba_mult_pipe.sv
// Self-checking bench for loba_mult_pipe: directed table, randomized traffic
// against an arithmetic reference model, backpressure and mid-flight reset.
module tb_loba_mult_pipe;

  localparam int unsigned N = 16;
  localparam int unsigned K = 4;

  logic          clk, rst, in_valid, in_ready, sgn, out_valid, out_ready;
  logic [N-1:0]  a, b;
  logic [1:0]    mode;
  logic [2*N-1:0] r;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ready_mode = 0;  // 0: hold 1, 1: hold 0, 2: random
  int n_acc = 0;
  int n_out = 0;
  logic [31:0] cur_exp;
  logic [31:0] sb[$];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic        sgn;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[13];

  loba_mult_pipe #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .mode(mode), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready), .r(r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int msb_of(input longint unsigned x);
    int k = 0;
    while (x > 1) begin
      x = x >> 1;
      k++;
    end
    return k;
  endfunction

  // Reference: leading-window products from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [15:0] va, input logic [15:0] vb,
                                        input logic [1:0] vm, input logic vs);
    longint unsigned m[2], hi[2], lo[2];
    longint unsigned low, sum, full;
    int kh[2], kl[2];
    int ea, eb;
    logic neg;
    full = 64'd1 << 32;
    m[0] = (vs && va[15]) ? 64'd65536 - 64'(va) : 64'(va);
    m[1] = (vs && vb[15]) ? 64'd65536 - 64'(vb) : 64'(vb);
    neg  = vs && (va[15] ^ vb[15]);
    for (int j = 0; j < 2; j++) begin
      kh[j] = msb_of(m[j]);
      if (kh[j] < int'(K) - 1) kh[j] = int'(K) - 1;
      hi[j] = (m[j] >> (kh[j] - int'(K) + 1)) % 64'(1 << K);
      low   = m[j] % (64'd1 << (kh[j] - int'(K) + 1));
      kl[j] = msb_of(low);
      if (kl[j] < int'(K) - 1) kl[j] = int'(K) - 1;
      lo[j] = (low >> (kl[j] - int'(K) + 1)) % 64'(1 << K);
    end
    sum = 0;
    for (int i = 0; i <= int'(vm); i++) begin
      ea  = (i < 2) ? kh[0] : kl[0];
      eb  = (i % 2 == 1) ? kl[1] : kh[1];
      sum += ((i < 2) ? hi[0] : lo[0]) * ((i % 2 == 1) ? lo[1] : hi[1])
             * (64'd1 << (ea + eb - 2 * (int'(K) - 1)));
    end
    sum = sum % full;
    if (neg) sum = (full - sum) % full;
    return 32'(sum);
  endfunction

  task automatic send(input logic [15:0] va, input logic [15:0] vb, input logic [1:0] vm,
                      input logic vs, input logic [31:0] ve, output int waits);
    logic acc;
    a = va; b = vb; mode = vm; sgn = vs; cur_exp = ve; in_valid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 100) begin
        check("send_timeout", 64'(waits), 64'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Counts falling edges from an accept until out_valid shows up.
  task automatic latency_probe(input string name);
    int n = 0;
    int w;
    send(16'd1000, 16'd3, 2'd0, 1'b0, 32'd2880, w);
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check(name, 64'(n), 64'd3);
  endtask

  // Output handshake driver
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Scoreboard: expected values enter on accept and leave on output transfer
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      n_acc = 0;
      n_out = 0;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back(cur_exp);
        n_acc++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) check("unexpected_out", 64'(sb.size()), 64'd1);
        else check("result", 64'(r), 64'(sb.pop_front()));
      end
    end
  end

  initial begin
    int w, stalls, idx;
    logic [31:0] held;
    logic have_r;
    logic [15:0] ra, rb;
    logic [1:0] rm;
    logic rs;
    logic [15:0] bp_a[6];

    tbl[0]  = '{16'd1000,  16'd3,      2'd0, 1'b0, 32'd2880};
    tbl[1]  = '{16'd1000,  16'd3,      2'd2, 1'b0, 32'd3000};
    tbl[2]  = '{16'hFC18,  16'd3,      2'd2, 1'b1, 32'hFFFFF448};
    tbl[3]  = '{16'hFC18,  16'd3,      2'd2, 1'b0, 32'h0002F400};
    tbl[4]  = '{16'h00FF,  16'h00FF,   2'd0, 1'b0, 32'd57600};
    tbl[5]  = '{16'h00FF,  16'h00FF,   2'd1, 1'b0, 32'd61200};
    tbl[6]  = '{16'h00FF,  16'h00FF,   2'd2, 1'b0, 32'd64800};
    tbl[7]  = '{16'h00FF,  16'h00FF,   2'd3, 1'b0, 32'd65025};
    tbl[8]  = '{16'd0,     16'h7FFF,   2'd3, 1'b1, 32'd0};
    tbl[9]  = '{16'd0,     16'h7FFF,   2'd1, 1'b0, 32'd0};
    tbl[10] = '{16'h8000,  16'd1,      2'd3, 1'b1, 32'hFFFF8000};
    tbl[11] = '{16'hFFFF,  16'hFFFF,   2'd0, 1'b1, 32'd1};
    tbl[12] = '{16'hFFFF,  16'd0,      2'd3, 1'b1, 32'd0};

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = '0; sgn = 1'b0; cur_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_r", 64'(r), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1);

    latency_probe("latency_initial");
    drain();

    // Directed vectors back to back
    stalls = 0;
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].sgn, tbl[i].exp, w);
      stalls += w;
    end
    check("b2b_no_stall", 64'(stalls), 64'd0);
    idle(1);
    drain();

    // Randomized traffic with random output backpressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 16'd0;
        1: ra = 16'h8000;
        2: ra = 16'($urandom_range(0, 255));
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      rm = 2'($urandom_range(0, 3));
      rs = 1'($urandom_range(0, 1));
      send(ra, rb, rm, rs, model(ra, rb, rm, rs), w);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    ready_mode = 0;
    idle(2);
    drain();

    // Backpressure: six beats against a stalled output for five cycles
    ready_mode = 1;
    idle(3);
    for (int i = 0; i < 6; i++) bp_a[i] = 16'(100 + 37 * i);
    idx = 0;
    have_r = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      a = bp_a[idx]; b = 16'd77; mode = 2'd3; sgn = 1'b0;
      cur_exp = model(bp_a[idx], 16'd77, 2'd3, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      if (out_valid) begin
        if (have_r) check("bp_r_stable", 64'(r), 64'(held));
        else begin
          held = r;
          have_r = 1'b1;
        end
      end
      w = int'(in_ready);
      @(posedge clk);
      #1;
      if (w != 0) idx++;
    end
    in_valid = 1'b0;
    check("bp_buffered", 64'(idx), 64'd3);
    @(negedge clk);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_out_valid_held", 64'(out_valid), 64'd1);
    check("bp_r_stable_last", 64'(r), 64'(held));
    @(posedge clk);
    #1;
    ready_mode = 0;
    while (idx < 6) begin
      send(bp_a[idx], 16'd77, 2'd3, 1'b0, model(bp_a[idx], 16'd77, 2'd3, 1'b0), w);
      idx++;
    end
    idle(2);
    drain();
    check("bp_all_delivered", 64'(n_out), 64'(n_acc));

    // Reset with the pipe full
    ready_mode = 1;
    idle(2);
    for (int i = 0; i < 3; i++) send(16'(500 + i), 16'd9, 2'd1, 1'b0, model(16'(500 + i), 16'd9, 2'd1, 1'b0), w);
    idle(2);
    check("full_before_rst", 64'(out_valid), 64'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid_now", 64'(out_valid), 64'd0);
    check("rst_r_now", 64'(r), 64'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    ready_mode = 0;
    idle(2);
    latency_probe("latency_after_rst");
    idle(2);
    drain();
    check("final_count", 64'(n_out), 64'(n_acc));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
